// File: rtl/adc_capture_pkg.sv
// Shared state encoding and widths for the ADC capture controller.
package adc_capture_pkg;

    localparam int STATE_W     = 2;
    localparam int TRIG_MISS_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_cap_peak.sv
// One lane's absolute-value peak tracker; a clear beats a same-cycle update.
module adc_cap_peak #(
    parameter int SAMP_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              clr,
    input  logic [SAMP_W-1:0] sample,
    output logic [SAMP_W-1:0] level
);

    logic [SAMP_W-1:0] abs_val;

    // The most negative sample negates to itself, which reads correctly as 2^(SAMP_W-1) unsigned.
    always_comb begin
        abs_val = sample[SAMP_W-1] ? (-sample) : sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (clr) begin
            level <= '0;
        end else if (valid && (abs_val > level)) begin
            level <= abs_val;
        end
    end

endmodule

// File: rtl/adc_capture_ctl.sv
// ADC capture controller: armed/triggered length-limited capture, trigger-miss count, peak snapshots.
// Define ADC_CAP_NOISE_SW_EN to build the rxq_sw_ctl toggle generator used in noise mode.
module adc_capture_ctl
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int SAMP_W  = 14,
    parameter int LANE_W  = 16,
    parameter int LEN_W   = 24,
    parameter int SW_HALF = 1525,
    parameter int TIMO_W  = 6
) (
    input  logic                     adc_clk,
    input  logic                     adc_resetn,
    input  logic                     adc_valid,
    input  logic [NUM_CH*LANE_W-1:0] adc_data,
    input  logic                     xfer_req,
    input  logic                     trig_in,
    input  logic                     noise_mode,
    input  logic [LEN_W-1:0]         cap_len,
    input  logic                     abort,
    input  logic                     clr_max,
    input  logic                     peak_ack,
    output logic                     cap_wr,
    output logic [NUM_CH*LANE_W-1:0] cap_data,
    output logic                     cap_active,
    output logic                     cap_done,
    output logic [LEN_W-1:0]         cap_cnt,
    output logic [STATE_W-1:0]       state,
    output logic [TRIG_MISS_W-1:0]   trig_miss,
    output logic                     peak_req,
    output logic [NUM_CH*LANE_W-1:0] peak,
    output logic                     rxq_sw_ctl
);

    cap_state_t               state_q, state_d;
    logic                     xfer_req_d, trig_in_d, clr_max_d, xfer_rise_q;
    logic                     trig_rise, trig, clr_rise, wr_now, len_hit, done_d;
    logic [LEN_W-1:0]         cnt_inc;
    logic [TIMO_W-1:0]        timo_cnt;
    logic [NUM_CH*LANE_W-1:0] peak_live;

    // The xfer_req edge is registered, so arming lands two cycles after the request rises.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            xfer_req_d  <= 1'b0;
            trig_in_d   <= 1'b0;
            clr_max_d   <= 1'b0;
            xfer_rise_q <= 1'b0;
        end else begin
            xfer_req_d  <= xfer_req;
            trig_in_d   <= trig_in;
            clr_max_d   <= clr_max;
            xfer_rise_q <= xfer_req & ~xfer_req_d;
        end
    end

    always_comb begin
        trig_rise = trig_in & ~trig_in_d;
        trig      = trig_rise | noise_mode;
        clr_rise  = clr_max & ~clr_max_d;
        wr_now    = adc_valid && (state_q == ST_CAPTURE);
        cnt_inc   = (&cap_cnt) ? cap_cnt : cap_cnt + LEN_W'(1);
        len_hit   = wr_now && (cap_len != '0) && (cnt_inc == cap_len);
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_rise_q) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!xfer_req) begin
                    state_d = ST_IDLE;
                end else if (abort) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (trig) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!xfer_req) begin
                    state_d = ST_IDLE;
                end else if (abort || len_hit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (!xfer_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            state_q   <= ST_IDLE;
            cap_wr    <= 1'b0;
            cap_data  <= '0;
            cap_done  <= 1'b0;
            cap_cnt   <= '0;
            trig_miss <= '0;
        end else begin
            state_q  <= state_d;
            cap_wr   <= wr_now;
            cap_data <= adc_data;
            cap_done <= done_d;
            if ((state_q == ST_IDLE) && (state_d == ST_ARMED)) begin
                cap_cnt <= '0;
            end else if (wr_now) begin
                cap_cnt <= cnt_inc;
            end
            if ((state_q == ST_IDLE) && trig_rise && !(&trig_miss)) begin
                trig_miss <= trig_miss + TRIG_MISS_W'(1);
            end
        end
    end

    assign state      = state_q;
    assign cap_active = (state_q == ST_CAPTURE);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic [SAMP_W-1:0] lane_level;

        adc_cap_peak #(.SAMP_W(SAMP_W)) u_peak (
            .clk    (adc_clk),
            .rst_n  (adc_resetn),
            .valid  (adc_valid),
            .clr    (clr_rise),
            .sample (adc_data[LANE_W*i +: SAMP_W]),
            .level  (lane_level)
        );

        assign peak_live[LANE_W*i +: LANE_W] = LANE_W'(lane_level);
    end

    // A snapshot is held until acknowledged or timed out, then reloaded after one idle cycle.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            peak_req <= 1'b0;
            peak     <= '0;
            timo_cnt <= '0;
        end else if (!peak_req) begin
            peak_req <= 1'b1;
            peak     <= peak_live;
            timo_cnt <= '0;
        end else if (peak_ack || (&timo_cnt)) begin
            peak_req <= 1'b0;
        end else begin
            timo_cnt <= timo_cnt + TIMO_W'(1);
        end
    end

`ifdef ADC_CAP_NOISE_SW_EN
    localparam int SW_CNT_W = (SW_HALF > 1) ? $clog2(SW_HALF) : 1;

    logic [SW_CNT_W-1:0] sw_cnt;

    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            sw_cnt     <= '0;
            rxq_sw_ctl <= 1'b0;
        end else if (!noise_mode) begin
            sw_cnt     <= '0;
            rxq_sw_ctl <= 1'b0;
        end else if (sw_cnt == SW_CNT_W'(SW_HALF - 1)) begin
            sw_cnt     <= '0;
            rxq_sw_ctl <= ~rxq_sw_ctl;
        end else begin
            sw_cnt <= sw_cnt + SW_CNT_W'(1);
        end
    end
`else
    assign rxq_sw_ctl = 1'b0;
`endif

endmodule

// File: doc/adc_capture_ctl.md
# adc_capture_ctl

Parametrised ADC capture controller: gates a multi-channel ADC sample stream into the capture FIFO path after an armed trigger, stops automatically after a programmed length, and tracks per-channel absolute peak levels with a snapshot handshake. Sits in the adc_clk domain between the JESD/TPL sample output and the ADC-to-AXI widening stage. All control inputs arrive already synchronised to adc_clk; CDC is handled outside the block.

## Interface
- NUM_CH, 4, sample lanes per beat
- SAMP_W, 14, signed sample bits per lane (LSB-aligned)
- LANE_W, 16, lane width in adc_data/peak
- LEN_W, 24, capture-length counter width
- SW_HALF, 1525, rxq_sw_ctl half-period in adc_clk cycles
- TIMO_W, 6, peak-snapshot timeout counter width

- adc_clk  in  1  sample clock
- adc_resetn  in  1  asynchronous, active-low reset
- adc_valid  in  1  sample beat valid
- adc_data  in  NUM_CH*LANE_W  lane i at [LANE_W*i +: SAMP_W], two's complement
- xfer_req  in  1  DMA transfer request level
- trig_in  in  1  trigger level (DAC transmitting); rising edge triggers
- noise_mode  in  1  level; trigger immediately, enable rxq switch toggling
- cap_len  in  LEN_W  beats per capture; 0 = unlimited
- abort  in  1  level; ends capture
- clr_max  in  1  rising edge clears peaks
- peak_ack  in  1  consumer acknowledge of snapshot
- cap_wr  out  1  registered write strobe to FIFO path
- cap_data  out  NUM_CH*LANE_W  registered copy of adc_data
- cap_active  out  1  high in CAPTURE
- cap_done  out  1  one-cycle pulse on length reached or abort
- cap_cnt  out  LEN_W  beats written this capture
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- trig_miss  out  8  saturating count of trigger edges seen in IDLE
- peak_req  out  1  snapshot valid
- peak  out  NUM_CH*LANE_W  snapshot of per-lane |sample| max, zero-extended
- rxq_sw_ctl  out  1  RX switch control

## Operation
- Edge detection: xfer_req, trig_in, clr_max compared against one-cycle delayed registers. trig = trig_in rise OR noise_mode.
- FSM: IDLE→ARMED on xfer_req rise. ARMED→CAPTURE on trig. CAPTURE→DONE when a write makes cap_cnt == cap_len (cap_len≠0), or on abort. DONE→IDLE when xfer_req low. xfer_req low in ARMED/CAPTURE → IDLE, no cap_done. abort in ARMED → DONE with cap_done.
- cap_cnt cleared on ARMED entry; increments per cap_wr; in unlimited mode saturates at all-ones (writes continue).
- Last write and abort in same cycle: write issued, single cap_done.
- Peak per lane: abs = negate if sign bit; most-negative value yields 2^(SAMP_W-1) (fits SAMP_W unsigned, no overflow). Update on adc_valid when abs > stored. clr_max rise clears; clear wins over simultaneous update.
- Snapshot: when peak_req low, load peak from trackers and raise peak_req next cycle; drop peak_req cycle after peak_ack or after 2^TIMO_W cycles without ack; reload following cycle.
- trig_miss: trig_in rise while IDLE increments, saturates at 255.

## Timing
- Reset: state=IDLE, all outputs 0, peak trackers 0, trig_miss 0.
- xfer_req rise at cycle n (sampled) → state ARMED at n+2 (edge register + FSM register).
- trig at cycle n in ARMED → cap_active at n+1; first cap_wr for adc_valid beat at n+1 appears at n+2.
- cap_wr/cap_data latency 1 cycle from adc_valid/adc_data; cap_wr only for beats presented while state==CAPTURE.
- cap_done coincides with DONE entry cycle.
- Reset asserted mid-capture: immediate return to IDLE, cap_wr drops asynchronously.

## Configuration
- ADC_CAP_NOISE_SW_EN defined: rxq_sw_ctl toggles every SW_HALF cycles while noise_mode high, forced 0 (counter reloaded) when noise_mode low.
- Undefined: counter omitted, rxq_sw_ctl tied 0; noise_mode still acts as trigger.

## Structure
- Package adc_capture_pkg: state encoding localparams (ST_IDLE..ST_DONE), width of state and trig_miss.
- Sub-module adc_cap_peak: one lane's abs + max tracker with clear, generated NUM_CH times.

## Test plan
- xfer_req rise, trig_in rise, cap_len=8, continuous adc_valid → exactly 8 cap_wr, cap_done once, state DONE, cap_cnt=8; xfer_req low → IDLE.
- cap_len=0, abort after 100 beats → 100 writes, cap_done pulse, no writes after.
- trig_in rises twice in IDLE, 300 times total → trig_miss=255 saturated; no cap_wr.
- Lane 0 samples 0x2000 (−8192), lane 1 +100 → peak lane0=8192, lane1=100; clr_max rise → next snapshot 0.
- peak_ack never asserted, TIMO_W=6 → peak_req high 64 cycles, low 1, reloads.
- ADC_CAP_NOISE_SW_EN, noise_mode=1, SW_HALF=4 → rxq_sw_ctl period 8 cycles, capture starts immediately after arming.
